// File: rtl/prog_loader_if.sv
// Byte-stream receive channel and instruction-memory write port of the program loader.
// The slave modport is the loader's view; the master modport is the byte source / memory side.
interface prog_loader_if #(
  parameter int ADDR_W = 10
);
  // rx handshake: a byte transfers in any cycle where rx_valid and rx_ready are both high.
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: parses framed program images from a byte stream, writes words to instruction
// memory, verifies an additive checksum and releases the core from reset on success.
module prog_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  prog_loader_if.slave     bus,
  output logic             cpu_reset,
  output logic             load_done,
  output logic             load_error,
  output logic [1:0]       err_code,
  output logic [2:0]       dbg_state
);
  localparam int              MAX_WORDS = 2 ** ADDR_W;
  localparam int              TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [7:0]      MAGIC     = 8'hA5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_LO = 3'd1,
    CNT_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [15:0]       n_q, n_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       buf_q, buf_d;
  logic [7:0]        sum_q, sum_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              load_done_q, load_done_d;
  logic              load_error_q, load_error_d;
  logic              accept;
  logic              counting;
  logic              last_word;
  logic [15:0]       n_full;

  assign bus.rx_ready = 1'b1;
  assign accept       = bus.rx_valid;
  assign counting     = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                        (state_q == DATA)   || (state_q == CHECK);
  assign n_full       = {bus.rx_data, cnt_lo_q};
  assign last_word    = {{(32-ADDR_W){1'b0}}, word_idx_q} == ({16'd0, n_q} - 32'd1);

  always_comb begin
    state_d      = state_q;
    err_code_d   = err_code_q;
    cnt_lo_d     = cnt_lo_q;
    n_d          = n_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    buf_d        = buf_q;
    sum_d        = sum_q;
    tmo_d        = tmo_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    if (accept) begin
      tmo_d = '0;
    end else if (counting) begin
      tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (accept && bus.rx_data == MAGIC) begin
          state_d    = CNT_LO;
          err_code_d = 2'd0;
          word_idx_d = '0;
          byte_idx_d = '0;
          sum_d      = '0;
        end
      end
      CNT_LO: if (accept) begin
        cnt_lo_d = bus.rx_data;
        state_d  = CNT_HI;
      end
      CNT_HI: if (accept) begin
        n_d = n_full;
        if (n_full == 16'd0 || {16'd0, n_full} > 32'(MAX_WORDS)) begin
          state_d    = ERROR;
          err_code_d = 2'd1;
        end else begin
          state_d = DATA;
        end
      end
      DATA: if (accept) begin
        sum_d      = sum_q + bus.rx_data;
        byte_idx_d = byte_idx_q + 2'd1;
        case (byte_idx_q)
          2'd0: buf_d[7:0]   = bus.rx_data;
          2'd1: buf_d[15:8]  = bus.rx_data;
          2'd2: buf_d[23:16] = bus.rx_data;
          default: begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q;
            imem_wdata_d = {bus.rx_data, buf_q};
            // Index stays put on the last word so it never wraps past MAX_WORDS-1.
            if (last_word) state_d = CHECK;
            else           word_idx_d = word_idx_q + 1'b1;
          end
        endcase
      end
      CHECK: if (accept) begin
        if (sum_q + bus.rx_data == 8'd0) begin
          state_d = DONE;
        end else begin
          state_d    = ERROR;
          err_code_d = 2'd2;
        end
      end
      default: state_d = IDLE;
    endcase

    // An accepted byte in the same cycle always beats the timeout.
    if (!accept && counting && tmo_q == TMO_LAST) begin
      state_d    = ERROR;
      err_code_d = 2'd3;
    end
  end

  assign cpu_reset_d  = (state_d != DONE);
  assign load_done_d  = (state_d == DONE);
  assign load_error_d = (state_d == ERROR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      err_code_q   <= 2'd0;
      cnt_lo_q     <= '0;
      n_q          <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      buf_q        <= '0;
      sum_q        <= '0;
      tmo_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_code_q   <= err_code_d;
      cnt_lo_q     <= cnt_lo_d;
      n_q          <= n_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      buf_q        <= buf_d;
      sum_q        <= sum_d;
      tmo_q        <= tmo_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign cpu_reset      = cpu_reset_q;
  assign load_done      = load_done_q;
  assign load_error     = load_error_q;
  assign err_code       = err_code_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are built with their checksum, expected memory
// writes are queued as frames are built and popped by a write monitor.
module tb_prog_loader;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 16;
  localparam int W       = ADDR_W + 32;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CNT_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  logic       clk;
  logic       reset;
  logic       cpu_reset;
  logic       load_done;
  logic       load_error;
  logic [1:0] err_code;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   frm[$];
  logic [31:0]  words[$];

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error),
    .err_code   (err_code),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // write monitor / scoreboard
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {22'd0, bus.imem_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("write_addr", {22'd0, bus.imem_addr}, {22'd0, e[W-1:32]});
        check("write_data", bus.imem_wdata, e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(frm[i]);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Builds A5, count, data, checksum from words[]; bad_cs corrupts the checksum by +1.
  task automatic build_frame(input logic bad_cs);
    logic [7:0]  sum;
    logic [15:0] n;
    logic [31:0] w;
    sum = 8'd0;
    n   = 16'(words.size());
    frm.delete();
    frm.push_back(8'hA5);
    frm.push_back(n[7:0]);
    frm.push_back(n[15:8]);
    for (int k = 0; k < words.size(); k++) begin
      w = words[k];
      for (int j = 0; j < 4; j++) begin
        frm.push_back(w[8*j +: 8]);
        sum = sum + w[8*j +: 8];
      end
      exp_q.push_back({ADDR_W'(k), w});
    end
    frm.push_back(8'd0 - sum + {7'd0, bad_cs});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    #2;
    check("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
    check("rst_imem_addr", {22'd0, bus.imem_addr}, 32'd0);
    check("rst_imem_wdata", bus.imem_wdata, 32'd0);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_load_error", {31'd0, load_error}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic [1:0] code, input logic cpu_rst);
    check({tag, "_load_done"}, {31'd0, load_done}, {31'd0, done});
    check({tag, "_load_error"}, {31'd0, load_error}, {31'd0, err});
    check({tag, "_err_code"}, {30'd0, err_code}, {30'd0, code});
    check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, cpu_rst});
  endtask

  initial begin
    int cyc;
    reset        = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    pulse_reset();
    check("rx_ready", {31'd0, bus.rx_ready}, 32'd1);

    // Two-word frame with good checksum
    words = '{32'h0000_0013, 32'h0010_0093};
    build_frame(1'b0);
    send_range(0, frm.size() - 1);
    check_status("good2", 1'b1, 1'b0, 2'd0, 1'b0);
    idle(2);
    check("good2_queue", exp_q.size(), 32'd0);

    // Restart from DONE
    send_byte(8'hA5);
    bus.rx_valid = 1'b0;
    check_status("restart_done", 1'b0, 1'b0, 2'd0, 1'b1);
    pulse_reset();

    // Same frame with checksum off by one: writes still happen
    build_frame(1'b1);
    send_range(0, frm.size() - 1);
    check_status("badcs", 1'b0, 1'b1, 2'd2, 1'b1);
    idle(3);
    check("badcs_hold", {30'd0, err_code}, 32'd2);
    check("badcs_queue", exp_q.size(), 32'd0);

    // Zero length, then over-length
    frm = '{8'hA5, 8'h00, 8'h00};
    send_range(0, 2);
    check_status("len0", 1'b0, 1'b1, 2'd1, 1'b1);
    frm = '{8'hA5, 8'h01, 8'h04};
    send_range(0, 2);
    check_status("len1025", 1'b0, 1'b1, 2'd1, 1'b1);
    idle(2);

    // Exactly MAX_WORDS is accepted
    frm = '{8'hA5, 8'h00, 8'h04};
    send_range(0, 2);
    check("len1024_state", {29'd0, dbg_state}, {29'd0, S_DATA});
    pulse_reset();

    // Leading junk in IDLE is ignored
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(1);
    check("junk_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    words = '{32'hDEAD_BEEF};
    build_frame(1'b0);
    send_range(0, frm.size() - 1);
    check_status("beef", 1'b1, 1'b0, 2'd0, 1'b0);
    idle(2);

    // Random three-word frame
    words = '{};
    for (int i = 0; i < 3; i++) words.push_back({$urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF)});
    build_frame(1'b0);
    send_range(0, frm.size() - 1);
    check_status("rand3", 1'b1, 1'b0, 2'd0, 1'b0);
    idle(2);

    // Timeout after two data bytes
    pulse_reset();
    frm = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE};
    send_range(0, 4);
    cyc = 0;
    while (load_error !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("tmo_cycles", cyc, TIMEOUT);
    check_status("tmo", 1'b0, 1'b1, 2'd3, 1'b1);
    check("tmo_state", {29'd0, dbg_state}, {29'd0, S_ERROR});

    // Restart from ERROR and finish the frame
    words = '{32'hCAFE_F00D};
    build_frame(1'b0);
    send_range(0, 0);
    check_status("restart_err", 1'b0, 1'b0, 2'd0, 1'b1);
    check("restart_state", {29'd0, dbg_state}, {29'd0, S_CNT_LO});
    send_range(1, frm.size() - 1);
    check_status("restart_load", 1'b1, 1'b0, 2'd0, 1'b0);
    idle(2);

    // Reset after word 0 of a two-word frame
    pulse_reset();
    words = '{32'h1122_3344, 32'h5566_7788};
    build_frame(1'b0);
    void'(exp_q.pop_back());
    send_range(0, 8);
    idle(1);
    pulse_reset();
    send_range(9, frm.size() - 1);
    idle(2);
    check("abort_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    check_status("abort", 1'b0, 1'b0, 2'd0, 1'b1);
    check("abort_queue", exp_q.size(), 32'd0);
    build_frame(1'b0);
    send_range(0, frm.size() - 1);
    check_status("fresh", 1'b1, 1'b0, 2'd0, 1'b0);
    check("fresh_state", {29'd0, dbg_state}, {29'd0, S_DONE});
    idle(3);
    check("final_queue", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
